// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_rx_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module ps2_byte_fifo
  import ps2_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clrDrdy,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              do_push, do_pop, ovf_q;

  assign do_pop  = rd && (cnt != '0);
  assign do_push = wr && ((cnt != FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge clrDrdy) begin
    if (clrDrdy) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= wr && !do_push;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  // Storage has no reset; dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign count    = cnt;
  assign overflow = ovf_q;
  assign dout     = empty ? '0 : mem[rp];
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM, timeout, byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo
  import ps2_rx_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 2000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            clrDrdy,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [DATA_W-1:0]               dout,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic                clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILT_LEN-1:0] filt_sr;
  logic                filt_clk, fall;
  rx_state_e           state, state_d;
  logic [2:0]          bitcnt, bitcnt_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic                pbit, pbit_d;
  logic                push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [TW-1:0]       tcnt, quiet;
  logic                armed, timeout, par_good, parity_ok;

  always_ff @(posedge clk or posedge clrDrdy) begin
    if (clrDrdy) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2_data;
      dat_s2  <= dat_s1;
      filt_sr <= {filt_sr[FILT_LEN-2:0], clk_s2};
      if (filt_clk && (filt_sr == '0))    filt_clk <= 1'b0;
      else if (!filt_clk && (&filt_sr))   filt_clk <= 1'b1;
    end
  end

  assign fall = filt_clk && (filt_sr == '0);

  // After reset, wait for a quiet high line so a frame cut by reset is not decoded.
  always_ff @(posedge clk or posedge clrDrdy) begin
    if (clrDrdy) begin
      quiet <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      if (!filt_clk)            quiet <= '0;
      else if (quiet == T_LAST) armed <= 1'b1;
      else                      quiet <= quiet + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clrDrdy) begin
    if (clrDrdy)                      tcnt <= '0;
    else if (state == IDLE || fall)   tcnt <= '0;
    else                              tcnt <= tcnt + 1'b1;
  end

  assign timeout  = (state != IDLE) && (tcnt == T_LAST);
  assign par_good = ^{shift, pbit};
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = par_good;
`else
  // pbit is still captured; its check is folded away.
  assign parity_ok = par_good | 1'b1;
`endif

  always_comb begin
    state_d  = state;
    bitcnt_d = bitcnt;
    shift_d  = shift;
    pbit_d   = pbit;
    push_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: if (!dat_s2 && armed) begin
          state_d  = DATA;
          bitcnt_d = '0;
          shift_d  = '0;
        end
        DATA: begin
          shift_d  = {dat_s2, shift[DATA_W-1:1]};
          bitcnt_d = bitcnt + 1'b1;
          if (bitcnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          pbit_d  = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2)        ferr_d = 1'b1;
          else if (parity_ok) push_d = 1'b1;
          else                perr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clrDrdy) begin
    if (clrDrdy) begin
      state  <= IDLE;
      bitcnt <= '0;
      shift  <= '0;
      pbit   <= 1'b0;
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_d;
      bitcnt <= bitcnt_d;
      shift  <= shift_d;
      pbit   <= pbit_d;
      push_q <= push_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .clrDrdy  (clrDrdy),
    .wr       (push_q),
    .din      (shift),
    .rd       (rd_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a byte scoreboard and pulse counters.
module tb_ps2_rx_fifo;
  import ps2_rx_pkg::*;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 4;
  localparam int HALF        = 25;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          clrDrdy = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    dout;
  logic          empty, full, parity_err, frame_err, overflow;
  logic [CW-1:0] count;

  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  int e_perr = 0, e_ferr = 0, e_ovf = 0;

  ps2_rx_fifo #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .clrDrdy    (clrDrdy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Counting high cycles means a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic odd_p(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic check_pulses(input string tag);
    check({tag, "_perr"}, 32'(n_perr), 32'(e_perr));
    check({tag, "_ferr"}, 32'(n_ferr), 32'(e_ferr));
    check({tag, "_ovf"},  32'(n_ovf),  32'(e_ovf));
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 11);
    end else begin
      wait_cyc(HALF);
    end
  endtask

  // pop_at_push raises rd_en in exactly the cycle the stop-bit push lands.
  task automatic send_frame(input logic [7:0] b, input logic p, input int glitch_at,
                            input bit pop_at_push);
    bit seen;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch_at == i);
    ps2_bit(p, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    if (pop_at_push) begin
      seen = 1'b0;
      for (int k = 0; k < 2 * HALF && !seen; k++) begin
        @(negedge clk);
        if (dut.push_q) begin
          seen = 1'b1;
          check("pop_in_push_head", 32'(dout), 32'(exp_q.pop_front()));
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end
      end
      check("push_seen", 32'(seen), 32'd1);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b1;
    wait_cyc(HALF + 20);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      check(tag, 32'(dout), 32'(exp_q.pop_front()));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    end
  endtask

  initial begin
    wait_cyc(3);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    clrDrdy = 1'b0;
    wait_cyc(TIMEOUT_CYC + 20);
    check_pulses("idle");

    // Good frame 0x1C, pbit 0.
    send_frame(8'h1C, 1'b0, -1, 1'b0);
    exp_q.push_back(8'h1C);
    check("f1c_empty", 32'(empty), 32'd0);
    check("f1c_dout", 32'(dout), 32'h1C);
    check("f1c_count", 32'(count), 32'd1);
    check_pulses("f1c");

    // 0xF0 with pbit 0 has even parity.
    send_frame(8'hF0, 1'b0, -1, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    e_perr++;
`else
    exp_q.push_back(8'hF0);
`endif
    check("ff0_count", 32'(count), 32'(exp_q.size()));
    check_pulses("ff0");
    while (exp_q.size() != 0) pop_check("drain1");
    check("drain1_empty", 32'(empty), 32'd1);

    // Short low glitch on ps2_clk during bit 3.
    send_frame(8'h5A, odd_p(8'h5A), 3, 1'b0);
    exp_q.push_back(8'h5A);
    check("glitch_count", 32'(count), 32'd1);
    check_pulses("glitch");
    pop_check("glitch_pop");

    // Truncated frame: start + 4 data bits, then line idle.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    wait_cyc(TIMEOUT_CYC + 10);
    e_ferr++;
    check("tmo_state", 32'(dut.state), 32'(IDLE));
    check("tmo_count", 32'(count), 32'd0);
    check_pulses("tmo");
    send_frame(8'h12, odd_p(8'h12), -1, 1'b0);
    exp_q.push_back(8'h12);
    check_pulses("after_tmo");
    pop_check("after_tmo_pop");

    // Fill past capacity.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), odd_p(8'(i)), -1, 1'b0);
      if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
      else e_ovf++;
      if (i == FIFO_DEPTH - 1) check("fill3_full", 32'(full), 32'd0);
      if (i == FIFO_DEPTH) check("fill4_full", 32'(full), 32'd1);
    end
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_full", 32'(full), 32'd1);
    check_pulses("ovf");
    while (exp_q.size() != 0) pop_check("drain_ovf");
    check("drain_ovf_empty", 32'(empty), 32'd1);

    // Full FIFO, pop coinciding with push.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send_frame(8'h21 + 8'(i), odd_p(8'h21 + 8'(i)), -1, 1'b0);
      exp_q.push_back(8'h21 + 8'(i));
    end
    check("pp_full_before", 32'(full), 32'd1);
    send_frame(8'h25, odd_p(8'h25), -1, 1'b1);
    exp_q.push_back(8'h25);
    check("pp_count", 32'(count), 32'd4);
    check_pulses("pp");
    while (exp_q.size() != 0) pop_check("drain_pp");
    check("drain_pp_empty", 32'(empty), 32'd1);
    check("drain_pp_dout", 32'(dout), 32'd0);

    // Extra pop on an empty FIFO is ignored.
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check("pop_empty_count", 32'(count), 32'd0);
    check_pulses("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
